// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the full-duplex FIFO-buffered UART.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;

   typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_ODD = 2'd1, PAR_EVEN = 2'd2} parity_t;

   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_t;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_t;

   // Parity bit that gives the frame the requested odd/even count of ones.
   function automatic logic parity_bit(logic [7:0] data, parity_t mode);
      return (mode == PAR_ODD) ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_baudrate_gen.sv
// Oversampling tick generator: one-cycle pulse every DIV clocks.
module uart_baudrate_gen #(
   parameter int unsigned DIV = 54
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO, depth 2**AW, extra pointer MSB for full/empty.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, rptr_q;
   logic             do_push, do_pop;

   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
         if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/uart_fifo.sv
// Full-duplex UART with TX/RX FIFOs, 16x oversampled receiver and per-byte error flags.
module uart_fifo
   import uart_pkg::*;
#(
   parameter real         CLK_FREQ = 100_000_000.0,
   parameter int unsigned BAUDRATE = 115_200,
   parameter int unsigned DATA_BIT = 8,
   parameter int unsigned STOP_BIT = 1,
   parameter int unsigned PARITY   = 0,
   parameter int unsigned FIFO_AW  = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                tx_wr,
   input  logic [DATA_BIT-1:0] tx_data,
   output logic                tx_full,
   output logic                tx_idle,
   input  logic                rx_rd,
   output logic [DATA_BIT-1:0] rx_data,
   output logic                rx_frame_err,
   output logic                rx_parity_err,
   output logic                rx_empty,
   output logic                rx_overrun,
   input  logic                err_clr,
   input  logic                rx,
   output logic                tx
);

   localparam int          DIV_R     = $rtoi(CLK_FREQ / (real'(OVERSAMPLE) * BAUDRATE) + 0.5);
   localparam int unsigned DIV       = (DIV_R < 1) ? 32'd1 : unsigned'(DIV_R);
   localparam parity_t     PAR       = parity_t'(2'(PARITY));
   localparam logic [2:0]  LAST_BIT  = 3'(DATA_BIT - 1);
   localparam logic [2:0]  LAST_STOP = 3'(STOP_BIT - 1);
   localparam logic [3:0]  TICK_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0]  TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

   logic tick;

   uart_baudrate_gen #(.DIV(DIV)) u_baud (.clk(clk), .reset_n(reset_n), .tick(tick));

   // ---------------- TX ----------------
   logic [DATA_BIT-1:0] txf_rdata, tx_shift_q;
   logic                txf_empty, tx_pop, tx_bit_done, tx_frame_done, tx_par_q, tx_q;
   logic [3:0]          tx_tick_q;
   logic [2:0]          tx_bit_q;
   tx_state_t           tx_state_q;

   uart_sync_fifo #(.WIDTH(DATA_BIT), .AW(FIFO_AW)) u_tx_fifo (
      .clk(clk), .reset_n(reset_n), .push(tx_wr), .wdata(tx_data), .pop(tx_pop),
      .rdata(txf_rdata), .full(tx_full), .empty(txf_empty)
   );

   assign tx_bit_done   = tick && (tx_tick_q == TICK_LAST);
   assign tx_frame_done = (tx_state_q == TxStop) && tx_bit_done && (tx_bit_q == LAST_STOP);
   // Popping at the end of the last stop bit chains frames with no idle gap.
   assign tx_pop        = !txf_empty && ((tx_state_q == TxIdle) || tx_frame_done);
   assign tx_idle       = txf_empty && (tx_state_q == TxIdle);
   assign tx            = tx_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_q <= TxIdle;
         tx_tick_q  <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else if (tx_pop) begin
         tx_state_q <= TxStart;
         tx_tick_q  <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= txf_rdata;
         tx_par_q   <= parity_bit(8'(txf_rdata), PAR);
         tx_q       <= 1'b0;
      end else if (tx_frame_done) begin
         tx_state_q <= TxIdle;
         tx_q       <= 1'b1;
      end else if (tick && tx_state_q != TxIdle) begin
         tx_tick_q <= tx_tick_q + 4'd1;
         if (tx_tick_q == TICK_LAST) begin
            unique case (tx_state_q)
               TxStart: begin
                  tx_state_q <= TxData;
                  tx_bit_q   <= '0;
                  tx_q       <= tx_shift_q[0];
                  tx_shift_q <= tx_shift_q >> 1;
               end
               TxData: begin
                  if (tx_bit_q == LAST_BIT) begin
                     tx_state_q <= (PAR != PAR_NONE) ? TxParity : TxStop;
                     tx_q       <= (PAR != PAR_NONE) ? tx_par_q : 1'b1;
                     tx_bit_q   <= '0;
                  end else begin
                     tx_bit_q   <= tx_bit_q + 3'd1;
                     tx_q       <= tx_shift_q[0];
                     tx_shift_q <= tx_shift_q >> 1;
                  end
               end
               TxParity: begin
                  tx_state_q <= TxStop;
                  tx_bit_q   <= '0;
                  tx_q       <= 1'b1;
               end
               TxStop:  tx_bit_q <= tx_bit_q + 3'd1;
               default: tx_state_q <= TxIdle;
            endcase
         end
      end
   end

   // ---------------- RX ----------------
   logic                rx_meta_q, rx_sync_q, rx_prev_q, rx_fall, rx_par_q;
   logic                rx_sample, rx_push, rx_perr, rxf_full, rx_overrun_q;
   logic [DATA_BIT-1:0] rx_shift_q;
   logic [DATA_BIT+1:0] rxf_wdata, rxf_rdata;
   logic [3:0]          rx_tick_q;
   logic [2:0]          rx_bit_q;
   rx_state_t           rx_state_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign rx_fall   = rx_prev_q && !rx_sync_q;
   assign rx_sample = tick && (rx_tick_q == TICK_LAST);
   assign rx_push   = (rx_state_q == RxStop) && rx_sample;
   assign rx_perr   = (PAR != PAR_NONE) && (rx_par_q != parity_bit(8'(rx_shift_q), PAR));
   assign rxf_wdata = {rx_perr, !rx_sync_q, rx_shift_q};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_q <= RxIdle;
         rx_tick_q  <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
      end else begin
         unique case (rx_state_q)
            RxIdle: begin
               rx_tick_q <= '0;
               if (rx_fall) rx_state_q <= RxStart;
            end
            RxStart: if (tick) begin
               rx_tick_q <= rx_tick_q + 4'd1;
               if (rx_tick_q == TICK_MID) begin
                  rx_tick_q  <= '0;
                  rx_bit_q   <= '0;
                  rx_state_q <= rx_sync_q ? RxIdle : RxData;
               end
            end
            RxData: if (tick) begin
               rx_tick_q <= rx_tick_q + 4'd1;
               if (rx_tick_q == TICK_LAST) begin
                  rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BIT-1:1]};
                  rx_bit_q   <= rx_bit_q + 3'd1;
                  if (rx_bit_q == LAST_BIT) begin
                     rx_state_q <= (PAR != PAR_NONE) ? RxParity : RxStop;
                  end
               end
            end
            RxParity: if (tick) begin
               rx_tick_q <= rx_tick_q + 4'd1;
               if (rx_tick_q == TICK_LAST) begin
                  rx_par_q   <= rx_sync_q;
                  rx_state_q <= RxStop;
               end
            end
            RxStop: if (tick) begin
               rx_tick_q <= rx_tick_q + 4'd1;
               if (rx_tick_q == TICK_LAST) rx_state_q <= RxIdle;
            end
            default: rx_state_q <= RxIdle;
         endcase
      end
   end

   uart_sync_fifo #(.WIDTH(DATA_BIT + 2), .AW(FIFO_AW)) u_rx_fifo (
      .clk(clk), .reset_n(reset_n), .push(rx_push), .wdata(rxf_wdata), .pop(rx_rd),
      .rdata(rxf_rdata), .full(rxf_full), .empty(rx_empty)
   );

   // A dropped frame outranks a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_overrun_q <= 1'b0;
      end else if (rx_push && rxf_full) begin
         rx_overrun_q <= 1'b1;
      end else if (err_clr) begin
         rx_overrun_q <= 1'b0;
      end
   end

   assign rx_overrun    = rx_overrun_q;
   assign rx_data       = rxf_rdata[DATA_BIT-1:0];
   assign rx_frame_err  = !rx_empty && rxf_rdata[DATA_BIT];
   assign rx_parity_err = !rx_empty && rxf_rdata[DATA_BIT+1];

endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: an even-parity instance (with tx->rx loopback) and an odd one.
module tb_uart_fifo;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       e_tx_wr, e_tx_full, e_tx_idle, e_rx_rd, e_fe, e_pe, e_rx_empty, e_ovr;
   logic       e_err_clr, e_rx, e_tx, e_drv, loop;
   logic [7:0] e_tx_data, e_rx_data;
   logic       o_tx_wr, o_tx_full, o_tx_idle, o_rx_rd, o_fe, o_pe, o_rx_empty, o_ovr;
   logic       o_err_clr, o_tx, o_drv;
   logic [7:0] o_tx_data, o_rx_data;

   assign e_rx = loop ? e_tx : e_drv;

   exp_t q_e[$];
   exp_t q_o[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_e = 1'b1;

   uart_fifo #(.CLK_FREQ(1_600_000.0), .BAUDRATE(100_000), .DATA_BIT(8), .STOP_BIT(1),
               .PARITY(2), .FIFO_AW(4)) u_even (
      .clk(clk), .reset_n(reset_n), .tx_wr(e_tx_wr), .tx_data(e_tx_data), .tx_full(e_tx_full),
      .tx_idle(e_tx_idle), .rx_rd(e_rx_rd), .rx_data(e_rx_data), .rx_frame_err(e_fe),
      .rx_parity_err(e_pe), .rx_empty(e_rx_empty), .rx_overrun(e_ovr), .err_clr(e_err_clr),
      .rx(e_rx), .tx(e_tx)
   );

   uart_fifo #(.CLK_FREQ(1_600_000.0), .BAUDRATE(100_000), .DATA_BIT(8), .STOP_BIT(1),
               .PARITY(1), .FIFO_AW(4)) u_odd (
      .clk(clk), .reset_n(reset_n), .tx_wr(o_tx_wr), .tx_data(o_tx_data), .tx_full(o_tx_full),
      .tx_idle(o_tx_idle), .rx_rd(o_rx_rd), .rx_data(o_rx_data), .rx_frame_err(o_fe),
      .rx_parity_err(o_pe), .rx_empty(o_rx_empty), .rx_overrun(o_ovr), .err_clr(o_err_clr),
      .rx(o_drv), .tx(o_tx)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Even-parity bit: set when the data holds an odd number of ones.
   function automatic logic par_even(input logic [7:0] d);
      return ($countones(d) % 2) == 1;
   endfunction

   function automatic exp_t mk(input logic [7:0] d, input logic fe, input logic pe);
      exp_t e;
      e.d  = d;
      e.fe = fe;
      e.pe = pe;
      return e;
   endfunction

   // Monitors: pop the head whenever the DUT presents one and compare with the scoreboard.
   initial begin
      exp_t x;
      e_rx_rd = 1'b0;
      forever begin
         @(negedge clk);
         e_rx_rd = 1'b0;
         if (mon_e && reset_n && !e_rx_empty) begin
            if (q_e.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL even unexpected entry: got 0x%0h expected none", e_rx_data);
            end else begin
               x = q_e.pop_front();
               chk("even rx entry", {e_rx_data, e_fe, e_pe}, x);
            end
            e_rx_rd = 1'b1;
         end
      end
   end

   initial begin
      exp_t x;
      o_rx_rd = 1'b0;
      forever begin
         @(negedge clk);
         o_rx_rd = 1'b0;
         if (reset_n && !o_rx_empty) begin
            if (q_o.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL odd unexpected entry: got 0x%0h expected none", o_rx_data);
            end else begin
               x = q_o.pop_front();
               chk("odd rx entry", {o_rx_data, o_fe, o_pe}, x);
            end
            o_rx_rd = 1'b1;
         end
      end
   end

   task automatic drive_bit(input bit odd_inst, input logic v);
      if (odd_inst) o_drv = v;
      else e_drv = v;
      repeat (16) @(negedge clk);
   endtask

   task automatic send_frame(input bit odd_inst, input logic [7:0] d, input logic p,
                             input logic stop);
      drive_bit(odd_inst, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(odd_inst, d[i]);
      drive_bit(odd_inst, p);
      drive_bit(odd_inst, stop);
      drive_bit(odd_inst, 1'b1);
   endtask

   task automatic wait_drain(input string name, input bit odd_inst, input int budget);
      int n = 0;
      while ((odd_inst ? q_o.size() : q_e.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk(name, odd_inst ? q_o.size() : q_e.size(), 0);
   endtask

   initial begin
      logic [10:0] fr;
      logic [7:0]  b;
      int          n, idle_at, cnt;
      bit          busy, push, pop;

      reset_n   = 1'b0;
      loop      = 1'b0;
      e_drv     = 1'b1;
      o_drv     = 1'b1;
      e_tx_wr   = 1'b0;
      o_tx_wr   = 1'b0;
      e_tx_data = 8'h00;
      o_tx_data = 8'h00;
      e_err_clr = 1'b0;
      o_err_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset tx", e_tx, 1);
      chk("reset tx_idle", e_tx_idle, 1);
      chk("reset tx_full", e_tx_full, 0);
      chk("reset rx_empty", e_rx_empty, 1);
      chk("reset rx_overrun", e_ovr, 0);
      chk("reset rx_frame_err", e_fe, 0);
      chk("reset rx_parity_err", e_pe, 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // 1: single even-parity frame of 0xA5 on the serial output
      e_tx_data = 8'hA5;
      e_tx_wr   = 1'b1;
      @(negedge clk);
      e_tx_wr = 1'b0;
      n = 0;
      while (e_tx !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t1 start bit seen", e_tx, 0);
      fr[0]   = 1'b0;
      fr[8:1] = 8'hA5;
      fr[9]   = par_even(8'hA5);
      fr[10]  = 1'b1;
      idle_at = -1;
      for (int c = 0; c < 200; c++) begin
         if (c % 16 == 8 && c / 16 < 11) chk($sformatf("t1 tx bit %0d", c / 16), e_tx, fr[c / 16]);
         if (e_tx_idle && idle_at < 0) idle_at = c;
         @(negedge clk);
      end
      chk("t1 tx_idle latency", idle_at, 176);

      // 2: loopback burst of 20 writes; model FIFO decides which are accepted
      loop = 1'b1;
      cnt  = 0;
      busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         b         = 8'($urandom);
         e_tx_data = b;
         e_tx_wr   = 1'b1;
         push      = (cnt < 16);
         pop       = !busy && cnt > 0;
         if (push) q_e.push_back(mk(b, 1'b0, 1'b0));
         cnt = cnt + int'(push) - int'(pop);
         if (pop) busy = 1'b1;
         @(negedge clk);
      end
      e_tx_wr = 1'b0;
      chk("t2 tx_full", e_tx_full, cnt == 16);
      wait_drain("t2 loopback drained", 1'b0, 5000);
      n = 0;
      while (!e_tx_idle && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("t2 tx_idle", e_tx_idle, 1);
      loop = 1'b0;
      repeat (20) @(negedge clk);

      // 3: stop bit driven low
      q_e.push_back(mk(8'h3C, 1'b1, 1'b0));
      send_frame(1'b0, 8'h3C, par_even(8'h3C), 1'b0);
      wait_drain("t3 frame error drained", 1'b0, 300);

      // 4: odd parity means the ones count including the parity bit is odd
      for (int p = 0; p < 2; p++) begin
         q_o.push_back(mk(8'h01, 1'b0, 1'(p) != !par_even(8'h01)));
         send_frame(1'b1, 8'h01, 1'(p), 1'b1);
      end
      wait_drain("t4 parity drained", 1'b1, 300);

      // 5: 17 frames without reading; the 17th is dropped
      mon_e = 1'b0;
      for (int k = 0; k < 17; k++) begin
         b = 8'($urandom);
         if (k < 16) q_e.push_back(mk(b, 1'b0, 1'b0));
         send_frame(1'b0, b, par_even(b), 1'b1);
      end
      chk("t5 rx_overrun set", e_ovr, 1);
      e_err_clr = 1'b1;
      @(negedge clk);
      e_err_clr = 1'b0;
      chk("t5 rx_overrun cleared", e_ovr, 0);
      mon_e = 1'b1;
      wait_drain("t5 fifo drained", 1'b0, 200);
      chk("t5 rx_empty", e_rx_empty, 1);

      // 6: short glitch, then reset in the middle of a TX frame
      e_drv = 1'b0;
      repeat (4) @(negedge clk);
      e_drv = 1'b1;
      repeat (40) @(negedge clk);
      chk("t6 glitch rx_empty", e_rx_empty, 1);
      e_tx_data = 8'h00;
      e_tx_wr   = 1'b1;
      @(negedge clk);
      e_tx_wr = 1'b0;
      repeat (60) @(negedge clk);
      chk("t6 tx low mid-frame", e_tx, 0);
      reset_n = 1'b0;
      #1;
      chk("t6 reset tx", e_tx, 1);
      chk("t6 reset tx_idle", e_tx_idle, 1);
      chk("t6 reset rx_empty", e_rx_empty, 1);
      @(negedge clk);
      reset_n = 1'b1;
      n = 0;
      for (int c = 0; c < 250; c++) begin
         @(negedge clk);
         if (e_tx !== 1'b1) n++;
      end
      chk("t6 aborted frame not resent", n, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
